// File: rtl/melody_seq_pkg.sv
// Shared definitions for the melody sequencer: FSM states, step-word field
// positions, pattern depth and the tone_cfg packing helper.
package melody_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int NOTE_LSB = 0;
    localparam int NOTE_MSB = 3;
    localparam int OCT_LSB  = 4;
    localparam int OCT_MSB  = 5;
    localparam int REST_BIT = 6;
    localparam int END_BIT  = 7;

    localparam int         STEP_WORDS = 16;
    localparam logic [7:0] END_WORD   = 8'h80;
    localparam int         TICK_W     = 24;

    // Packs a step word into the tone generator layout {tremolo, gate, octave, note}.
    function automatic logic [7:0] make_tone(input logic [7:0] word,
                                             input logic       gate_en,
                                             input logic       trem);
        return {trem, gate_en & ~word[REST_BIT],
                word[OCT_MSB:OCT_LSB], word[NOTE_MSB:NOTE_LSB]};
    endfunction

endpackage

// File: rtl/melody_step_timer.sv
// Per-step tick counter. o_gap_active describes the tick value being loaded on
// the coming edge. The gap comparator exists only when MELODY_SEQ_GAP_EN is defined.
module melody_step_timer
    import melody_seq_pkg::*;
#(
    parameter int STEP_TICKS = 1000000,
    parameter int GAP_TICKS  = 100000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    input  logic i_clear,
    output logic o_step_end,
    output logic o_gap_active
);

    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] w_tick_next;

    assign o_step_end = (r_tick == TICK_W'(STEP_TICKS - 1));

    // Next tick: cleared outside PLAY, wraps to zero at the end of each step.
    always_comb begin
        w_tick_next = r_tick;
        if (i_clear) begin
            w_tick_next = {TICK_W{1'b0}};
        end else if (i_run) begin
            if (o_step_end) begin
                w_tick_next = {TICK_W{1'b0}};
            end else begin
                w_tick_next = r_tick + TICK_W'(1);
            end
        end else begin
            w_tick_next = r_tick;
        end
    end

`ifdef MELODY_SEQ_GAP_EN
    assign o_gap_active = (w_tick_next >= TICK_W'(STEP_TICKS - GAP_TICKS));
`else
    assign o_gap_active = 1'b0;
`endif

    // Tick register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick <= {TICK_W{1'b0}};
        end else begin
            r_tick <= w_tick_next;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// 16-step melody sequencer driving a tone generator's 8-bit config word.
// Optional articulation gap at each step's end is enabled by MELODY_SEQ_GAP_EN.
module melody_sequencer
    import melody_seq_pkg::*;
#(
    parameter int STEP_TICKS = 1000000,
    parameter int GAP_TICKS  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic       tremolo_in,
    output logic [7:0] tone_cfg,
    output logic [3:0] step_idx,
    output logic       busy,
    output logic       done
);

    state_e     r_state;
    logic [3:0] r_step_idx;
    logic [7:0] r_tone_cfg;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_ram [STEP_WORDS];

    logic       w_step_end;
    logic       w_gap_active;
    logic       w_timer_run;
    logic       w_timer_clear;
    logic [3:0] w_next_idx;
    logic       w_seq_end;
    logic [3:0] w_adv_idx;

    assign tone_cfg = r_tone_cfg;
    assign step_idx = r_step_idx;
    assign busy     = r_busy;
    assign done     = r_done;

    assign w_timer_run   = (r_state == ST_PLAY) && !stop;
    assign w_timer_clear = !w_timer_run;

    melody_step_timer #(
        .STEP_TICKS (STEP_TICKS),
        .GAP_TICKS  (GAP_TICKS)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_run        (w_timer_run),
        .i_clear      (w_timer_clear),
        .o_step_end   (w_step_end),
        .o_gap_active (w_gap_active)
    );

    // Sequence-end detection for the step after the current one.
    always_comb begin
        w_next_idx = r_step_idx + 4'd1;
        w_seq_end  = (r_step_idx == 4'd15) || r_ram[w_next_idx][END_BIT];
        if (w_seq_end) begin
            w_adv_idx = 4'd0;
        end else begin
            w_adv_idx = w_next_idx;
        end
    end

    // Pattern RAM: reset to end markers, writable only while not playing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STEP_WORDS; i++) begin
                r_ram[i] <= END_WORD;
            end
        end else if (wr_en && (r_state != ST_PLAY)) begin
            r_ram[wr_addr] <= wr_data;
        end
    end

    // Sequencer FSM; tone_cfg is computed from the upcoming step and tick so it
    // lines up with step_idx and the timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_step_idx <= 4'd0;
            r_tone_cfg <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_tone_cfg <= 8'h00;
                    r_busy     <= 1'b0;
                    if (stop) begin
                        r_state    <= ST_IDLE;
                        r_step_idx <= 4'd0;
                    end else if (start) begin
                        r_step_idx <= 4'd0;
                        if (r_ram[0][END_BIT]) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= ST_PLAY;
                            r_busy     <= 1'b1;
                            r_tone_cfg <= make_tone(r_ram[0], ~w_gap_active, tremolo_in);
                        end
                    end
                end
                ST_PLAY: begin
                    if (stop) begin
                        r_state    <= ST_IDLE;
                        r_step_idx <= 4'd0;
                        r_tone_cfg <= 8'h00;
                        r_busy     <= 1'b0;
                    end else if (w_step_end) begin
                        if (w_seq_end && !loop) begin
                            r_state    <= ST_DONE;
                            r_step_idx <= 4'd0;
                            r_tone_cfg <= 8'h00;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                        end else begin
                            r_step_idx <= w_adv_idx;
                            r_tone_cfg <= make_tone(r_ram[w_adv_idx], ~w_gap_active, tremolo_in);
                        end
                    end else begin
                        r_tone_cfg <= make_tone(r_ram[r_step_idx], ~w_gap_active, tremolo_in);
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_step_idx <= 4'd0;
                    r_tone_cfg <= 8'h00;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
